// File: rtl/memory_controller.sv
// Two-phase register-file controller: requests are captured in IDLE and executed in ACCESS,
// returning registered value/error with a one-cycle memory_ready pulse per access.
module memory_controller #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_SIZE   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] value,
  output logic                  memory_ready,
  output logic                  error
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // Limit widened by one bit so MEM_SIZE == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];
  logic [DATA_WIDTH-1:0] r_value;
  logic                  r_error;
  logic                  r_ready;
  logic                  w_addr_valid;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_addr_valid = ({1'b0, r_addr} < MEM_LIMIT);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: strict alternation between capture and execute.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Read mux by explicit compare, so the index never leaves the implemented range.
  always_comb begin
    w_rd_data = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < MEM_SIZE; i++) begin
      if (r_addr == ADDR_WIDTH'(i)) begin
        w_rd_data = r_mem[i];
      end else begin
        w_rd_data = w_rd_data;
      end
    end
  end

  // Storage array: cleared by reset, written only when an in-range write executes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MEM_SIZE; i++) begin
      if (!rst_n) begin
        r_mem[i] <= {DATA_WIDTH{1'b0}};
      end else if ((r_state == ST_ACCESS) && r_we && w_addr_valid &&
                   (r_addr == ADDR_WIDTH'(i))) begin
        r_mem[i] <= r_data;
      end
    end
  end

  // Request capture and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_data  <= {DATA_WIDTH{1'b0}};
      r_addr  <= {ADDR_WIDTH{1'b0}};
      r_value <= {DATA_WIDTH{1'b0}};
      r_error <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_we    <= we;
          r_data  <= data;
          r_addr  <= addr;
          r_ready <= 1'b0;
        end
        ST_ACCESS: begin
          r_ready <= 1'b1;
          if (!w_addr_valid) begin
            r_value <= {DATA_WIDTH{1'b0}};
            r_error <= 1'b1;
          end else if (r_we) begin
            r_value <= r_data;
            r_error <= 1'b0;
          end else begin
            r_value <= w_rd_data;
            r_error <= 1'b0;
          end
        end
        default: begin
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign value        = r_value;
  assign error        = r_error;
  assign memory_ready = r_ready;

endmodule

// File: tb/tb_memory_controller.sv
// Scoreboard bench for memory_controller: directed scenarios followed by random traffic,
// expected results come from an array model of the word store.
module tb_memory_controller;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int MS = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic [DW-1:0] data = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] value;
  logic          memory_ready;
  logic          error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW:0]   exp_q[$];
  logic [DW-1:0] model_mem[MS];

  memory_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .data(data), .addr(addr),
    .value(value), .memory_ready(memory_ready), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference behaviour: returns {error, value} and updates the model store.
  function automatic logic [DW:0] model_access(input logic w, input logic [DW-1:0] d,
                                               input logic [AW-1:0] a);
    int ia = int'(a);
    if (ia >= MS) return {1'b1, {DW{1'b0}}};
    if (w) begin
      model_mem[ia] = d;
      return {1'b0, d};
    end
    return {1'b0, model_mem[ia]};
  endfunction

  // Issue one access from a negedge; inputs are scrambled during the execute cycle.
  task automatic do_access(input logic w, input logic [DW-1:0] d, input logic [AW-1:0] a);
    we = w; data = d; addr = a;
    exp_q.push_back(model_access(w, d, a));
    @(posedge clk); #1;
    check("ready_low_in_sample", {31'd0, memory_ready}, 32'd0);
    @(negedge clk);
    we = ~w; data = ~d ^ DW'($urandom); addr = a + AW'($urandom_range(1, 15));
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: every completion pulse is matched against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (memory_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 32'd1, 32'd0);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("value", {16'd0, value}, {16'd0, e[DW-1:0]});
          check("error", {31'd0, error}, {31'd0, e[DW]});
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < MS; i++) model_mem[i] = '0;
    we = 1'b1; data = 16'hFFFF; addr = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    check("reset_value", {16'd0, value}, 32'd0);
    check("reset_error", {31'd0, error}, 32'd0);
    check("reset_ready", {31'd0, memory_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_access(1'b0, 16'h0000, 4'd0);
    do_access(1'b1, 16'hBEEF, 4'd1);
    do_access(1'b0, 16'h0000, 4'd1);
    do_access(1'b0, 16'h0000, 4'd6);
    do_access(1'b0, 16'h0000, 4'd4);
    do_access(1'b1, 16'h1234, 4'd15);
    do_access(1'b1, 16'hA5A5, 4'd5);
    for (int i = 0; i < MS; i++) do_access(1'b0, 16'h0000, AW'(i));

    // Reset lands on the execute edge of a write to address 2.
    we = 1'b1; data = 16'hCAFE; addr = 4'd2;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_value", {16'd0, value}, 32'd0);
    check("midreset_error", {31'd0, error}, 32'd0);
    check("midreset_ready", {31'd0, memory_ready}, 32'd0);
    for (int i = 0; i < MS; i++) model_mem[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_access(1'b0, 16'h0000, 4'd2);
    do_access(1'b0, 16'h0000, 4'd1);

    for (int n = 0; n < 200; n++) begin
      do_access(1'($urandom_range(0, 1)), DW'($urandom), AW'($urandom_range(0, 15)));
    end

    rst_n = 1'b0;
    begin
      int budget = 10;
      while (exp_q.size() != 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      @(negedge clk);
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
